// File: rtl/lcd_win_ctrl.sv
// lcd_win_ctrl: loads a raster image into an internal frame buffer and, on
// each command, streams a WIN x WIN window of it. The window is either a
// decimated view of the whole image (FIT) or a 1:1 crop around a movable
// centre (ZOOM). It can optionally be mirrored horizontally.
// Ports:
//   clk, reset          rising-edge clock, async active-high reset
//   datain [DW]         pixel stream written during LOAD, raster order
//   cmd [4], cmd_valid  command code and strobe (ignored while busy)
//   dataout [DW]        window pixel, holds its value between windows
//   output_valid        qualifies dataout
//   busy                a command is in progress
module lcd_win_ctrl #(
  parameter int unsigned DW    = 8,
  parameter int unsigned IMG_W = 12,
  parameter int unsigned IMG_H = 9,
  parameter int unsigned WIN   = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] datain,
  input  logic [3:0]    cmd,
  input  logic          cmd_valid,
  output logic [DW-1:0] dataout,
  output logic          output_valid,
  output logic          busy
);

  localparam int unsigned TOTAL   = IMG_W * IMG_H;
  localparam int unsigned AW      = $clog2(TOTAL);
  localparam int unsigned CNTW    = $clog2(TOTAL + 1);
  localparam int unsigned WW      = $clog2(WIN);
  localparam int unsigned RW      = $clog2(IMG_H + 1);
  localparam int unsigned CW      = $clog2(IMG_W + 1);
  localparam int unsigned HALF    = WIN / 2;
  localparam int unsigned SY      = IMG_H / WIN;
  localparam int unsigned SX      = IMG_W / WIN;
  localparam int unsigned ROW_MAX = IMG_H - HALF;
  localparam int unsigned COL_MAX = IMG_W - HALF;
  localparam int unsigned ROW_DEF = (IMG_H + 1) / 2;
  localparam int unsigned COL_DEF = IMG_W / 2;

  localparam logic [3:0] CMD_LOAD     = 4'd0;
  localparam logic [3:0] CMD_ZOOM_IN  = 4'd1;
  localparam logic [3:0] CMD_ZOOM_FIT = 4'd2;
  localparam logic [3:0] CMD_RIGHT    = 4'd3;
  localparam logic [3:0] CMD_LEFT     = 4'd4;
  localparam logic [3:0] CMD_UP       = 4'd5;
  localparam logic [3:0] CMD_DOWN     = 4'd6;
  localparam logic [3:0] CMD_MIRROR   = 4'd8;

  typedef enum logic [1:0] {IDLE, EXEC, LOAD, OUT} state_t;

  state_t          state, state_nxt;
  logic            accept_c;
  logic            last_px_c;
  logic [CNTW-1:0] load_cnt;
  logic [WW-1:0]   win_i, win_j;
  logic [WW-1:0]   src_j_c;
  logic [AW-1:0]   src_row_c, src_col_c, rd_addr_c;
  logic            zoom;
  logic            mirror;
  logic [RW-1:0]   row_c;
  logic [CW-1:0]   col_c;
  logic [DW-1:0]   mem [TOTAL];

  assign last_px_c = (win_i == WW'(WIN - 1)) && (win_j == WW'(WIN - 1));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; busy is low exactly when IDLE, so IDLE implies acceptance
  always_comb begin
    state_nxt = state;
    accept_c  = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          accept_c  = 1'b1;
          state_nxt = (cmd == CMD_LOAD) ? LOAD : EXEC;
        end
      end
      EXEC:    state_nxt = OUT;
      // One extra cycle after the final write keeps the load latency aligned
      LOAD:    if (load_cnt == CNTW'(TOTAL)) state_nxt = OUT;
      OUT:     if (last_px_c) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Frame buffer write port; deliberately has no reset
  always_ff @(posedge clk) begin
    if (state == LOAD && load_cnt != CNTW'(TOTAL))
      mem[AW'(load_cnt)] <= datain;
  end

  // Load address and window position counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_cnt <= '0;
      win_i    <= '0;
      win_j    <= '0;
    end else begin
      if (accept_c)
        load_cnt <= '0;
      else if (state == LOAD && load_cnt != CNTW'(TOTAL))
        load_cnt <= load_cnt + CNTW'(1);

      if (state != OUT) begin
        win_i <= '0;
        win_j <= '0;
      end else if (win_j == WW'(WIN - 1)) begin
        win_j <= '0;
        win_i <= win_i + WW'(1);
      end else begin
        win_j <= win_j + WW'(1);
      end
    end
  end

  // View state: mode, mirror flag and zoom centre, updated on acceptance
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      zoom   <= 1'b0;
      mirror <= 1'b0;
      row_c  <= RW'(ROW_DEF);
      col_c  <= CW'(COL_DEF);
    end else begin
      if (accept_c) begin
        case (cmd)
          CMD_ZOOM_IN: begin
            if (!zoom) begin
              row_c <= RW'(ROW_DEF);
              col_c <= CW'(COL_DEF);
            end
            zoom <= 1'b1;
          end
          CMD_ZOOM_FIT: zoom <= 1'b0;
          CMD_RIGHT: if (zoom && col_c < CW'(COL_MAX)) col_c <= col_c + CW'(1);
          CMD_LEFT:  if (zoom && col_c > CW'(HALF))    col_c <= col_c - CW'(1);
          CMD_DOWN:  if (zoom && row_c < RW'(ROW_MAX)) row_c <= row_c + RW'(1);
          CMD_UP:    if (zoom && row_c > RW'(HALF))    row_c <= row_c - RW'(1);
          CMD_MIRROR: mirror <= ~mirror;
          default: ;
        endcase
      end
      if (state == LOAD && state_nxt == OUT)
        zoom <= 1'b0;
    end
  end

  // Source address of the current window pixel; centre bounds keep it in range
  always_comb begin
    src_j_c = mirror ? (WW'(WIN - 1) - win_j) : win_j;
    if (zoom) begin
      src_row_c = AW'(row_c) + AW'(win_i) - AW'(HALF);
      src_col_c = AW'(col_c) + AW'(src_j_c) - AW'(HALF);
    end else begin
      src_row_c = AW'(win_i) * AW'(SY) + AW'(SY / 2);
      src_col_c = AW'(src_j_c) * AW'(SX) + AW'(SX / 2);
    end
    rd_addr_c = src_row_c * AW'(IMG_W) + src_col_c;
  end

  // Registered outputs; dataout only updates while streaming
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy         <= 1'b0;
      output_valid <= 1'b0;
      dataout      <= '0;
    end else begin
      busy         <= (state_nxt != IDLE);
      output_valid <= (state == OUT);
      if (state == OUT)
        dataout <= mem[rd_addr_c];
    end
  end

endmodule

// File: tb/tb_lcd_win_ctrl.sv
// Directed bench for lcd_win_ctrl at default parameters (12x9 image, 4x4 window).
module tb_lcd_win_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] datain = '0;
  logic [3:0] cmd = '0;
  logic       cmd_valid = 1'b0;
  logic [7:0] dataout;
  logic       output_valid;
  logic       busy;

  int checks = 0;
  int passes = 0;

  logic [7:0] px [16];
  logic acc_busy, pre_ok, ov_ok, busy_ok, tail_ov;

  lcd_win_ctrl #(.DW(8), .IMG_W(12), .IMG_H(9), .WIN(4)) dut (
    .clk(clk), .reset(reset), .datain(datain), .cmd(cmd), .cmd_valid(cmd_valid),
    .dataout(dataout), .output_valid(output_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  // Issue one command and capture its window at the exact edges it is due.
  // lat = edges from acceptance to the first pixel; base = LOAD data start;
  // poke = pixel index at which a RIGHT is strobed while busy (-1 for none).
  task automatic run_cmd(input logic [3:0] c, input int lat, input int base, input int poke);
    @(negedge clk);
    cmd = c;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    acc_busy = busy;
    cmd_valid = 1'b0;
    cmd = '0;
    datain = 8'(base);
    pre_ok = 1'b1;
    for (int e = 1; e < lat; e++) begin
      @(posedge clk); #1;
      datain = 8'(base + e);
      if (output_valid !== 1'b0 || busy !== 1'b1) pre_ok = 1'b0;
    end
    ov_ok = 1'b1;
    busy_ok = 1'b1;
    for (int k = 0; k < 16; k++) begin
      if (k == poke) begin cmd = 4'd3; cmd_valid = 1'b1; end
      else cmd_valid = 1'b0;
      @(posedge clk); #1;
      px[k] = dataout;
      if (output_valid !== 1'b1) ov_ok = 1'b0;
      if (busy !== ((k < 15) ? 1'b1 : 1'b0)) busy_ok = 1'b0;
    end
    cmd_valid = 1'b0;
    cmd = '0;
    @(posedge clk); #1;
    tail_ov = output_valid;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passes++;
    checks++;
    if (output_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", output_valid); else passes++;
    checks++;
    if (dataout !== 8'd0) $display("FAIL reset_dataout: got %0d expected 0", dataout); else passes++;
    reset = 1'b0;
  endtask

  task automatic test_load_fit;
    int ew [16];
    ew = '{13, 16, 19, 22, 37, 40, 43, 46, 61, 64, 67, 70, 85, 88, 91, 94};
    run_cmd(4'd0, 110, 0, -1);
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (px[k] !== 8'(ew[k])) $display("FAIL load_fit px%0d: got %0d expected %0d", k, px[k], ew[k]);
      else passes++;
    end
    checks++;
    if ({acc_busy, pre_ok, ov_ok, busy_ok, tail_ov} !== 5'b11110)
      $display("FAIL load_fit handshake: got %b expected 11110", {acc_busy, pre_ok, ov_ok, busy_ok, tail_ov});
    else passes++;
  endtask

  task automatic test_zoom_pan;
    int ew [16];
    ew = '{40, 41, 42, 43, 52, 53, 54, 55, 64, 65, 66, 67, 76, 77, 78, 79};
    run_cmd(4'd1, 2, 0, -1);
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (px[k] !== 8'(ew[k])) $display("FAIL zoom_in px%0d: got %0d expected %0d", k, px[k], ew[k]);
      else passes++;
    end
    checks++;
    if ({acc_busy, pre_ok, ov_ok, busy_ok, tail_ov} !== 5'b11110)
      $display("FAIL zoom_in handshake: got %b expected 11110", {acc_busy, pre_ok, ov_ok, busy_ok, tail_ov});
    else passes++;
    for (int r = 0; r < 5; r++) begin
      run_cmd(4'd3, 2, 0, -1);
      checks++;
      if (px[0] !== 8'(41 + ((r < 3) ? r : 3)))
        $display("FAIL right%0d px0: got %0d expected %0d", r, px[0], 41 + ((r < 3) ? r : 3));
      else passes++;
    end
    ew = '{44, 45, 46, 47, 56, 57, 58, 59, 68, 69, 70, 71, 80, 81, 82, 83};
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (px[k] !== 8'(ew[k])) $display("FAIL right_sat px%0d: got %0d expected %0d", k, px[k], ew[k]);
      else passes++;
    end
    checks++;
    if ({acc_busy, pre_ok, ov_ok, busy_ok, tail_ov} !== 5'b11110)
      $display("FAIL right_sat handshake: got %b expected 11110", {acc_busy, pre_ok, ov_ok, busy_ok, tail_ov});
    else passes++;
  endtask

  task automatic test_mirror_fit;
    int ew [16];
    ew = '{47, 46, 45, 44, 59, 58, 57, 56, 71, 70, 69, 68, 83, 82, 81, 80};
    run_cmd(4'd8, 2, 0, -1);
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (px[k] !== 8'(ew[k])) $display("FAIL mirror px%0d: got %0d expected %0d", k, px[k], ew[k]);
      else passes++;
    end
    ew = '{22, 19, 16, 13, 46, 43, 40, 37, 70, 67, 64, 61, 94, 91, 88, 85};
    run_cmd(4'd2, 2, 0, -1);
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (px[k] !== 8'(ew[k])) $display("FAIL mirror_fit px%0d: got %0d expected %0d", k, px[k], ew[k]);
      else passes++;
    end
    checks++;
    if ({acc_busy, pre_ok, ov_ok, busy_ok, tail_ov} !== 5'b11110)
      $display("FAIL mirror_fit handshake: got %b expected 11110", {acc_busy, pre_ok, ov_ok, busy_ok, tail_ov});
    else passes++;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (dataout !== 8'd85 || output_valid !== 1'b0)
      $display("FAIL hold_dataout: got %0d/%b expected 85/0", dataout, output_valid);
    else passes++;
  endtask

  task automatic test_busy_ignore;
    int ew [16];
    ew = '{43, 42, 41, 40, 55, 54, 53, 52, 67, 66, 65, 64, 79, 78, 77, 76};
    run_cmd(4'd1, 2, 0, 5);
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (px[k] !== 8'(ew[k])) $display("FAIL zoom_reentry px%0d: got %0d expected %0d", k, px[k], ew[k]);
      else passes++;
    end
    run_cmd(4'd7, 2, 0, -1);
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (px[k] !== 8'(ew[k])) $display("FAIL refresh px%0d: got %0d expected %0d", k, px[k], ew[k]);
      else passes++;
    end
    run_cmd(4'd12, 2, 0, -1);
    checks++;
    if (px[0] !== 8'd43 || px[15] !== 8'd76)
      $display("FAIL code12_refresh: got %0d,%0d expected 43,76", px[0], px[15]);
    else passes++;
    checks++;
    if ({acc_busy, pre_ok, ov_ok, busy_ok, tail_ov} !== 5'b11110)
      $display("FAIL code12 handshake: got %b expected 11110", {acc_busy, pre_ok, ov_ok, busy_ok, tail_ov});
    else passes++;
  endtask

  task automatic test_bounds;
    int up_px [4];
    int lf_px [5];
    int dn_px [6];
    up_px = '{28, 16, 4, 4};
    lf_px = '{3, 2, 1, 0, 0};
    dn_px = '{12, 24, 36, 48, 60, 60};
    run_cmd(4'd8, 2, 0, -1);
    checks++;
    if (px[0] !== 8'd40) $display("FAIL unmirror px0: got %0d expected 40", px[0]); else passes++;
    for (int r = 0; r < 4; r++) begin
      run_cmd(4'd5, 2, 0, -1);
      checks++;
      if (px[0] !== 8'(up_px[r])) $display("FAIL up%0d px0: got %0d expected %0d", r, px[0], up_px[r]);
      else passes++;
    end
    checks++;
    if (px[15] !== 8'd43) $display("FAIL up_sat px15: got %0d expected 43", px[15]); else passes++;
    for (int r = 0; r < 5; r++) begin
      run_cmd(4'd4, 2, 0, -1);
      checks++;
      if (px[0] !== 8'(lf_px[r])) $display("FAIL left%0d px0: got %0d expected %0d", r, px[0], lf_px[r]);
      else passes++;
    end
    checks++;
    if (px[15] !== 8'd39) $display("FAIL left_sat px15: got %0d expected 39", px[15]); else passes++;
    for (int r = 0; r < 6; r++) begin
      run_cmd(4'd6, 2, 0, -1);
      checks++;
      if (px[0] !== 8'(dn_px[r])) $display("FAIL down%0d px0: got %0d expected %0d", r, px[0], dn_px[r]);
      else passes++;
    end
    checks++;
    if (px[15] !== 8'd99) $display("FAIL down_sat px15: got %0d expected 99", px[15]); else passes++;
  endtask

  task automatic test_reset_mid_load;
    int ew [16];
    ew = '{113, 116, 119, 122, 137, 140, 143, 146, 61, 64, 67, 70, 85, 88, 91, 94};
    @(negedge clk);
    cmd = 4'd0;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    datain = 8'd100;
    for (int e = 1; e <= 50; e++) begin
      @(posedge clk); #1;
      datain = 8'(100 + e);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({busy, output_valid} !== 2'b00 || dataout !== 8'd0)
      $display("FAIL abort_immediate: got %b%b/%0d expected 00/0", busy, output_valid, dataout);
    else passes++;
    @(posedge clk); #1;
    checks++;
    if ({busy, output_valid} !== 2'b00)
      $display("FAIL abort_next_cycle: got %b%b expected 00", busy, output_valid);
    else passes++;
    reset = 1'b0;
    run_cmd(4'd2, 2, 0, -1);
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (px[k] !== 8'(ew[k])) $display("FAIL partial_load px%0d: got %0d expected %0d", k, px[k], ew[k]);
      else passes++;
    end
    checks++;
    if ({acc_busy, pre_ok, ov_ok, busy_ok, tail_ov} !== 5'b11110)
      $display("FAIL partial_load handshake: got %b expected 11110", {acc_busy, pre_ok, ov_ok, busy_ok, tail_ov});
    else passes++;
  endtask

  initial begin
    test_reset();
    test_load_fit();
    test_zoom_pan();
    test_mirror_fit();
    test_busy_ignore();
    test_bounds();
    test_reset_mid_load();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/lcd_win_ctrl.md
LCD_WIN_CTRL -- requirements
Module: lcd_win_ctrl

Interface
REQ-001 Parameters SHALL be: DW, default 8, pixel width; IMG_W, default 12, image columns; IMG_H, default 9, image rows; WIN, default 4, square output window side (even, WIN<=IMG_W, WIN<=IMG_H).
REQ-002 clk  input  1  rising-edge clock; the block SHALL have this one clock only.
REQ-003 reset  input  1  reset, asynchronous, active-high.
REQ-004 datain  input  DW  load pixel stream, raster order.
REQ-005 cmd  input  4  command code.
REQ-006 cmd_valid  input  1  command strobe.
REQ-007 dataout  output  DW  window pixel.
REQ-008 output_valid  output  1  dataout qualifier.
REQ-009 busy  output  1  command in progress; cmd_valid ignored while high.

Function
REQ-010 Command codes SHALL be: 0 LOAD, 1 ZOOM_IN, 2 ZOOM_FIT, 3 RIGHT, 4 LEFT, 5 UP, 6 DOWN, 7 REFRESH, 8 MIRROR (toggle horizontal mirror); codes 9-15 SHALL act as REFRESH.
REQ-011 A command SHALL be accepted at a rising edge where cmd_valid=1 and busy=0; busy SHALL be 1 from that edge.
REQ-012 FSM states SHALL be IDLE, EXEC, LOAD, OUT; IDLE->LOAD on accepted LOAD, IDLE->EXEC on any other accepted command, EXEC->OUT after 1 cycle, LOAD->OUT after IMG_W*IMG_H cycles, OUT->IDLE after WIN*WIN cycles.
REQ-013 LOAD SHALL store datain at each of the IMG_W*IMG_H edges following acceptance, into address 0 upward; on completion mode SHALL become FIT; the mirror flag is unchanged.
REQ-014 Buffer SHALL be IMG_W*IMG_H words of DW bits, not cleared by reset.
REQ-015 FIT mode: window pixel (i,j), 0<=i,j<WIN, SHALL read image(i*SY+SY/2, j*SX+SX/2), SY=IMG_H/WIN, SX=IMG_W/WIN (integer division).
REQ-016 ZOOM mode: pixel (i,j) SHALL read image(row-WIN/2+i, col-WIN/2+j), where (row,col) is the centre register.
REQ-017 Centre bounds SHALL be row in [WIN/2, IMG_H-WIN/2], col in [WIN/2, IMG_W-WIN/2]; default centre ((IMG_H+1)/2, IMG_W/2), i.e. (5,6) at defaults.
REQ-018 ZOOM_IN from FIT SHALL enter ZOOM and reload the default centre; ZOOM_IN while in ZOOM SHALL keep the centre.
REQ-019 ZOOM_FIT SHALL enter FIT and keep the centre register.
REQ-020 RIGHT/LEFT/DOWN/UP SHALL change col+1/col-1/row+1/row-1 in ZOOM only; at a bound, or in FIT, the centre SHALL be unchanged, and a window SHALL still be output.
REQ-021 With mirror=1, column j SHALL be taken from source column WIN-1-j; rows are unaffected; applies in both modes.
REQ-022 OUT SHALL present WIN*WIN pixels, raster order, one per cycle, output_valid=1 throughout.
REQ-023 For a non-LOAD command accepted at edge N, pixels SHALL appear at edges N+2 .. N+1+WIN*WIN; busy SHALL fall at edge N+1+WIN*WIN; output_valid SHALL fall one edge later.
REQ-024 For LOAD accepted at edge N, the first pixel SHALL appear at edge N+IMG_W*IMG_H+2.
REQ-025 Address arithmetic SHALL use unsigned widths sufficient for IMG_W*IMG_H-1; no wrap-around SHALL be possible within bounds.
REQ-026 dataout SHALL hold its last value when output_valid=0.

Reset
REQ-027 On reset: busy=0, output_valid=0, dataout=0, FSM=IDLE, mode=FIT, mirror=0, centre=default, counters=0.
REQ-028 Reset asserted mid-LOAD or mid-OUT SHALL abort immediately; the buffer keeps partially loaded contents.
REQ-029 The first command after reset SHALL be accepted with cmd_valid=1 in the first cycle after reset deasserts.

Verification
REQ-030 LOAD of values 0..107 (defaults) -> outputs 13,16,19,22,37,40,43,46,61,64,67,70,85,88,91,94; busy high for 108+17 cycles.
REQ-031 After the REQ-030 load, ZOOM_IN -> 40..43,52..55,64..67,76..79; then RIGHT x5 -> col saturates at 10, window 44..47,56..59,68..71,80..83.
REQ-032 After the REQ-031 sequence, MIRROR -> 47,46,45,44,59,...,80; ZOOM_FIT -> 22,19,16,13,46,...,85.
REQ-033 cmd_valid pulsed with cmd=3 while busy=1 -> ignored; centre unchanged; next accepted REFRESH reproduces the prior window.
REQ-034 Reset at pixel 50 of LOAD -> busy=0, output_valid=0 next cycle; subsequent ZOOM_FIT outputs the 16 FIT pixels with addresses <50 correct.
